// File: rtl/knight_rider_pkg.sv
// Shared encodings for the knight rider LED pattern generator.
package knight_rider_pkg;

  // Pattern select values as presented on the mode input.
  typedef enum logic [1:0] {
    SCAN     = 2'b00,
    CONVERGE = 2'b01,
    FILL     = 2'b10,
    BLINK    = 2'b11
  } mode_t;

  // Sweep direction: outward/up first, then return/down.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Mode selected out of reset.
  localparam mode_t MODE_RESET = SCAN;

endpackage

// File: rtl/knight_rider_gen_tick_prescaler.sv
// Programmable prescaler: emits a combinational tick on the clock edge that
// should advance the LED pattern, once every `period` enabled clocks.
module tick_prescaler #(
  parameter int CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] last;

  // A period of zero behaves like a period of one (tick every clock).
  assign last = (period == '0) ? '0 : period - CNT_W'(1);

  // Greater-or-equal so a period shortened mid-count expires immediately.
  // A clear always wins, so no tick is reported on a restart edge.
  assign tick = en & ~clear & (count >= last);

  // Count enabled clocks, wrapping on expiry and holding while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/knight_rider_gen.sv
// Knight rider LED pattern generator: SCAN, CONVERGE, FILL and BLINK patterns
// stepped by a programmable prescaler, with registered step/wrap pulses.
module knight_rider_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] period,
  output logic [WIDTH-1:0] data_out,
  output logic             dir,
  output logic             step,
  output logic             wrap
);

  import knight_rider_pkg::*;

  localparam int POS_W = $clog2(WIDTH);
  localparam logic [POS_W-1:0] POS_ZERO = '0;
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);
  localparam logic [POS_W-1:0] POS_MID  = POS_W'(WIDTH / 2 - 1);

  // The patterns assume a symmetric vector of a sensible size.
  if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > 32) begin : g_width_check
    $error("knight_rider_gen: WIDTH must be even and within 4..32");
  end

  mode_t            mode_in;
  mode_t            mode_q;
  mode_t            mode_n;
  dir_t             dir_q;
  dir_t             dir_n;
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_n;
  logic [POS_W-1:0] limit;
  logic [WIDTH-1:0] data_n;
  logic             step_n;
  logic             wrap_n;
  logic             mode_change;
  logic             tick;

  assign mode_in     = mode_t'(mode);
  assign mode_change = (mode_in != mode_q);
  assign dir         = dir_q;

  // LED image for a given pattern and position.
  function automatic logic [WIDTH-1:0] decode(input mode_t m, input logic [POS_W-1:0] p);
    logic [WIDTH-1:0] v;
    v = '0;
    case (m)
      SCAN: begin
        v[p] = 1'b1;
      end
      CONVERGE: begin
        v[p]            = 1'b1;
        v[POS_LAST - p] = 1'b1;
      end
      FILL: begin
        v = {WIDTH{1'b1}} >> (POS_LAST - p);
      end
      BLINK: begin
        v = (p == POS_ZERO) ? {WIDTH{1'b1}} : '0;
      end
      default: begin
        v = '0;
      end
    endcase
    return v;
  endfunction

  // A mode change clears the prescaler so the new pattern starts a full period.
  tick_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clear  (mode_change),
    .period (period),
    .tick   (tick)
  );

  // Next pattern state: restart on a mode change, otherwise bounce on each tick.
  always_comb begin
    mode_n = mode_q;
    pos_n  = pos_q;
    dir_n  = dir_q;
    step_n = 1'b0;
    wrap_n = 1'b0;
    limit  = POS_LAST;

    if (mode_change) begin
      mode_n = mode_in;
      pos_n  = POS_ZERO;
      dir_n  = DIR_UP;
    end else if (tick) begin
      step_n = 1'b1;
      case (mode_q)
        BLINK: begin
          if (pos_q == POS_ZERO) begin
            pos_n = POS_ONE;
            dir_n = DIR_DOWN;
          end else begin
            pos_n  = POS_ZERO;
            dir_n  = DIR_UP;
            wrap_n = 1'b1;
          end
        end
        default: begin
          limit = (mode_q == CONVERGE) ? POS_MID : POS_LAST;
          if (dir_q == DIR_UP) begin
            pos_n = pos_q + POS_ONE;
            if (pos_n == limit) begin
              dir_n = DIR_DOWN;
            end
          end else begin
            pos_n = pos_q - POS_ONE;
            if (pos_n == POS_ZERO) begin
              dir_n  = DIR_UP;
              wrap_n = 1'b1;
            end
          end
        end
      endcase
    end

    data_n = decode(mode_n, pos_n);
  end

  // Pattern state and all outputs are registered together so step lines up
  // with the edge that shows the new LED image.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_RESET;
      pos_q    <= POS_ZERO;
      dir_q    <= DIR_UP;
      data_out <= WIDTH'(1);
      step     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      mode_q   <= mode_n;
      pos_q    <= pos_n;
      dir_q    <= dir_n;
      data_out <= data_n;
      step     <= step_n;
      wrap     <= wrap_n;
    end
  end

endmodule
